// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences one measurement frame from ADC capture through
// FFT magnitude storage to the wave_freq analyser hand-off.
module fft_frame_ctrl #(
  parameter int FFT_LEN = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key,
  input  logic              auto_mode,
  input  logic [11:0]       adc_data,
  input  logic              adc_valid,
  output logic [15:0]       fft_s_data,
  output logic              fft_s_valid,
  output logic              fft_s_last,
  input  logic              fft_s_ready,
  input  logic [15:0]       fft_m_data,
  input  logic              fft_m_valid,
  input  logic              fft_m_last,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [15:0]       ram_wr_data,
  output logic              ana_en,
  input  logic              ana_valid,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              err_overrun,
  output logic              err_frame,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(FFT_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT,
    S_STORE,
    S_ANALYZE,
    S_HOLD,
    S_REARM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_key_s1;
  logic              r_key_s2;
  logic              r_key_d;
  logic [CNT_W-1:0]  r_scnt;
  logic [ADDR_W-1:0] r_bin;
  logic [TO_W-1:0]   r_to;
  logic [15:0]       r_s_data;
  logic              r_s_valid;
  logic              r_s_last;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_ana_en;
  logic [7:0]        r_frame_cnt;
  logic              r_err_ovr;
  logic              r_err_frm;
  logic              r_err_to;

  logic w_start_req;
  logic w_s_fire;
  logic w_cap_done;
  logic w_can_load;
  logic w_load;
  logic w_drop;
  logic w_beat;
  logic w_bin_last;
  logic w_store_end;
  logic w_to_hit;
  logic w_in_ana;
  logic w_next_ana;

  // key idles high; a press is its falling edge after synchronisation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_key_d  <= 1'b1;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
    end
  end

  assign w_start_req = r_key_d & ~r_key_s2;

  assign w_s_fire   = r_s_valid & fft_s_ready;
  assign w_cap_done = (r_state == S_CAPTURE) & w_s_fire & r_s_last;
  assign w_can_load = (r_state == S_CAPTURE) &
                      (r_scnt < CNT_W'(FFT_LEN));
  assign w_load     = w_can_load & adc_valid & fft_s_ready;
  assign w_drop     = w_can_load & adc_valid & ~fft_s_ready;

  // the first magnitude beat may arrive while still in WAIT
  assign w_beat      = fft_m_valid &
                       ((r_state == S_WAIT) | (r_state == S_STORE));
  assign w_bin_last  = (r_bin == ADDR_W'(FFT_LEN - 1));
  assign w_store_end = w_beat & (fft_m_last | w_bin_last);
  assign w_to_hit    = (r_state == S_WAIT) & ~fft_m_valid &
                       (r_to == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_req || auto_mode) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_cap_done) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_store_end)   w_next = S_ANALYZE;
        else if (w_beat)   w_next = S_STORE;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_STORE: begin
        if (w_store_end) w_next = S_ANALYZE;
      end
      S_ANALYZE: begin
        if (r_ana_en && ana_valid) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_start_req || auto_mode) w_next = S_REARM;
      end
      S_REARM: begin
        w_next = S_CAPTURE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // registered sample stage: a beat is replaced only when it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt    <= '0;
      r_s_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
    end else if (r_state != S_CAPTURE) begin
      r_scnt    <= '0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
    end else if (w_load) begin
      r_s_data  <= {{4{~adc_data[11]}}, ~adc_data[11], adc_data[10:0]};
      r_s_valid <= 1'b1;
      r_s_last  <= (r_scnt == CNT_W'(FFT_LEN - 1));
      r_scnt    <= r_scnt + CNT_W'(1);
    end else if (w_s_fire) begin
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to <= '0;
    end else if (r_state != S_WAIT) begin
      r_to <= '0;
    end else if (!fft_m_valid) begin
      r_to <= r_to + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_beat;
      if (w_beat) begin
        r_wr_addr <= r_bin;
        r_wr_data <= fft_m_data;
      end
      if ((r_state != S_WAIT) && (r_state != S_STORE)) begin
        r_bin <= '0;
      end else if (w_beat) begin
        r_bin <= r_bin + ADDR_W'(1);
      end
    end
  end

  // ana_en lags ANALYZE entry by one cycle, so it follows the last write
  assign w_in_ana   = (r_state == S_ANALYZE) | (r_state == S_HOLD);
  assign w_next_ana = (w_next == S_ANALYZE) | (w_next == S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ana_en    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_ana_en <= w_in_ana & w_next_ana;
      if ((r_state == S_ANALYZE) && (w_next == S_HOLD)) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovr <= 1'b0;
      r_err_frm <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      if (w_drop)   r_err_ovr <= 1'b1;
      if (w_to_hit) r_err_to  <= 1'b1;
      if (w_store_end && (fft_m_last != w_bin_last)) begin
        r_err_frm <= 1'b1;
      end
    end
  end

  assign fft_s_data  = r_s_data;
  assign fft_s_valid = r_s_valid;
  assign fft_s_last  = r_s_last;
  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_wr_data;
  assign ana_en      = r_ana_en;
  assign busy        = (r_state != S_IDLE) & (r_state != S_HOLD);
  assign frame_cnt   = r_frame_cnt;
  assign err_overrun = r_err_ovr;
  assign err_frame   = r_err_frm;
  assign err_timeout = r_err_to;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized frames against a transaction-level model
// of capture, magnitude storage, analyser hand-off and error flags.
module tb_fft_frame_ctrl;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        key;
  logic        auto_mode;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [15:0] fft_s_data;
  logic        fft_s_valid;
  logic        fft_s_last;
  logic        fft_s_ready;
  logic [15:0] fft_m_data;
  logic        fft_m_valid;
  logic        fft_m_last;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic        ana_en;
  logic        ana_valid;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        err_overrun;
  logic        err_frame;
  logic        err_timeout;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.FFT_LEN(N), .ADDR_W(8), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .key(key), .auto_mode(auto_mode),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .fft_s_data(fft_s_data), .fft_s_valid(fft_s_valid),
    .fft_s_last(fft_s_last), .fft_s_ready(fft_s_ready),
    .fft_m_data(fft_m_data), .fft_m_valid(fft_m_valid),
    .fft_m_last(fft_m_last),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ana_en(ana_en), .ana_valid(ana_valid), .busy(busy),
    .frame_cnt(frame_cnt), .err_overrun(err_overrun),
    .err_frame(err_frame), .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef enum int {P_ARM, P_CAP, P_STORE, P_ANA, P_DONE} ph_t;

  ph_t         ph;
  int          acc, beats, nwr;
  int          adc_pct, rdy_pct, mag_pct;
  int          lo_at, lo_left;
  int          ana_dly, ana_cnt;
  int          m_frames;
  bit          m_ovr, m_frm, m_to;
  bit          rearm_next, pend_rise, clr_auto;
  bit          prev_busy, prev_ana;
  logic [15:0] exp_s[$];
  logic [15:0] mag_d[$];
  logic        mag_l[$];
  logic [23:0] exp_wr[$];

  function automatic logic [15:0] conv(logic [11:0] d);
    return 16'(int'(d) - 2048);
  endfunction

  task automatic new_frame(int a_pct, int r_pct, int m_pct,
                           int last_at, int nb, bit ramp);
    logic [15:0] d;
    bit ended;
    ph = P_ARM; acc = 0; beats = 0; nwr = 0;
    adc_pct = a_pct; rdy_pct = r_pct; mag_pct = m_pct;
    lo_at = -1; lo_left = 0;
    rearm_next = 0; pend_rise = 0; clr_auto = 0;
    ana_dly = $urandom_range(0, 5);
    exp_s.delete(); mag_d.delete(); mag_l.delete(); exp_wr.delete();
    ended = 0;
    for (int k = 0; k < nb; k++) begin
      d = ramp ? 16'(k) : 16'($urandom);
      mag_d.push_back(d);
      mag_l.push_back(k == last_at);
      if (!ended) begin
        exp_wr.push_back({8'(k), d});
        if (k == last_at || k == N - 1) begin
          ended = 1;
          if (!(k == last_at && k == N - 1)) m_frm = 1;
        end
      end
    end
  endtask

  // one clock: drive inputs, score the current outputs, advance
  task automatic step();
    logic [23:0] w;
    if (ph == P_ARM) begin
      if (rearm_next) begin
        rearm_next = 0;
        ph = P_CAP;
        chk("rearm_busy", 32'(busy), 32'd1);
        chk("rearm_ana", 32'(ana_en), 32'd0);
      end else if (busy && !prev_busy) begin
        if (prev_ana) rearm_next = 1;
        else          ph = P_CAP;
      end
    end
    adc_valid   = (ph == P_CAP) && ($urandom_range(99) < adc_pct);
    adc_data    = 12'($urandom);
    if (acc == 0) adc_data = 12'h800;
    if (acc == 1) adc_data = 12'h000;
    fft_s_ready = ($urandom_range(99) < rdy_pct);
    if (ph == P_CAP && acc == lo_at && lo_left > 0) begin
      fft_s_ready = 1'b0;
      adc_valid   = 1'b1;
      lo_left--;
    end
    if ((ph == P_STORE || ph == P_ANA) && mag_d.size() > 0 &&
        $urandom_range(99) < mag_pct) begin
      fft_m_valid = 1'b1;
      fft_m_data  = mag_d.pop_front();
      fft_m_last  = mag_l.pop_front();
    end else begin
      fft_m_valid = 1'b0;
      fft_m_data  = 16'($urandom);
      fft_m_last  = 1'($urandom_range(1));
    end
    if (ana_en) ana_cnt++;
    else        ana_cnt = 0;
    ana_valid = ana_en && (ana_cnt > ana_dly);
    if (ph == P_ANA && ana_valid) begin
      m_frames++;
      ph = P_DONE;
      if (clr_auto) auto_mode = 1'b0;
    end
    if (fft_s_valid && fft_s_ready) begin
      if (ph != P_CAP || exp_s.size() == 0) begin
        chk("s_spurious", 32'(fft_s_valid), 32'd0);
      end else begin
        chk("s_data", 32'(fft_s_data), 32'(exp_s.pop_front()));
        chk("s_last", 32'(fft_s_last), 32'(beats == N - 1));
        beats++;
        if (beats == N) ph = P_STORE;
      end
    end
    if (ph == P_CAP && adc_valid && acc < N) begin
      if (fft_s_ready) begin
        exp_s.push_back(conv(adc_data));
        acc++;
      end else begin
        m_ovr = 1;
      end
    end
    if (pend_rise) begin
      chk("ana_rise", 32'(ana_en), 32'd1);
      pend_rise = 0;
    end
    if (ram_wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("wr_spurious", 32'(ram_wr_en), 32'd0);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 32'(ram_wr_addr), 32'(w[23:16]));
        chk("wr_data", 32'(ram_wr_data), 32'(w[15:0]));
        nwr++;
        if (exp_wr.size() == 0) begin
          chk("ana_pre", 32'(ana_en), 32'd0);
          pend_rise = 1;
          ph = P_ANA;
        end
      end
    end
    prev_busy = busy;
    prev_ana  = ana_en;
    @(posedge clk);
    #1;
  endtask

  task automatic press_key();
    key = 1'b0;
    repeat (3) step();
    key = 1'b1;
  endtask

  task automatic check_flags(string tag);
    chk({tag, "_ovr"}, 32'(err_overrun), 32'(m_ovr));
    chk({tag, "_frm"}, 32'(err_frame), 32'(m_frm));
    chk({tag, "_to"}, 32'(err_timeout), 32'(m_to));
  endtask

  task automatic run_frame(string tag, int abort_wr);
    int cyc;
    cyc = 0;
    while (ph != P_DONE && cyc < 20000) begin
      if (abort_wr > 0 && nwr >= abort_wr) return;
      step();
      cyc++;
    end
    chk({tag, "_done"}, 32'(ph == P_DONE), 32'd1);
    chk({tag, "_beats"}, 32'(beats), 32'(N));
    chk({tag, "_frames"}, 32'(frame_cnt), 32'(8'(m_frames)));
    chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hold_ana"}, 32'(ana_en), 32'd1);
    check_flags(tag);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_sv"}, 32'(fft_s_valid), 32'd0);
    chk({tag, "_sl"}, 32'(fft_s_last), 32'd0);
    chk({tag, "_sd"}, 32'(fft_s_data), 32'd0);
    chk({tag, "_we"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_wa"}, 32'(ram_wr_addr), 32'd0);
    chk({tag, "_wd"}, 32'(ram_wr_data), 32'd0);
    chk({tag, "_ana"}, 32'(ana_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fc"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_eo"}, 32'(err_overrun), 32'd0);
    chk({tag, "_ef"}, 32'(err_frame), 32'd0);
    chk({tag, "_et"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; key = 1'b1; auto_mode = 1'b0;
    adc_data = '0; adc_valid = 1'b0; fft_s_ready = 1'b1;
    fft_m_data = '0; fft_m_valid = 1'b0; fft_m_last = 1'b0;
    ana_valid = 1'b0; ana_cnt = 0;
    m_frames = 0; m_ovr = 0; m_frm = 0; m_to = 0;
    prev_busy = 0; prev_ana = 0;
    ph = P_ARM;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst = 1'b0;

    // clean frame, magnitude = bin
    new_frame(100, 100, 100, N - 1, N, 1);
    press_key();
    run_frame("f1", 0);

    // three dropped samples mid-capture
    new_frame(100, 100, 70, N - 1, N + 4, 0);
    lo_at = 100; lo_left = 3;
    press_key();
    run_frame("f2", 0);
    chk("f2_ovr_set", 32'(err_overrun), 32'd1);

    // no fft_m_last at all: stop at the last bin, flag it
    new_frame(70, 80, 60, -1, N + 4, 0);
    press_key();
    run_frame("f3", 0);

    // no magnitude stream: timeout back to idle
    new_frame(90, 90, 100, -1, 0, 0);
    press_key();
    cyc = 0;
    while (ph != P_STORE && cyc < 5000) begin
      step();
      cyc++;
    end
    chk("to_cap_done", 32'(ph == P_STORE), 32'd1);
    seen = 0;
    repeat (4090) begin
      step();
      if (ana_en) seen = 1;
    end
    chk("to_early", 32'(err_timeout), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    repeat (10) begin
      step();
      if (ana_en) seen = 1;
    end
    m_to = 1;
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_no_ana", 32'(seen), 32'd0);
    check_flags("to");

    // reset in the middle of STORE
    new_frame(100, 100, 80, N - 1, N, 0);
    press_key();
    run_frame("f6", 50);
    chk("f6_in_store", 32'(busy), 32'd1);
    rst = 1'b1;
    adc_valid = 1'b1; fft_s_ready = 1'b1; fft_m_valid = 1'b1;
    #1;
    check_zero("arst");
    @(posedge clk);
    #1;
    check_zero("arst_edge");
    rst = 1'b0;
    adc_valid = 1'b0; fft_m_valid = 1'b0; ana_valid = 1'b0;
    m_frames = 0; m_ovr = 0; m_frm = 0; m_to = 0;
    prev_busy = 0; prev_ana = 0; ana_cnt = 0;

    new_frame(85, 85, 75, N - 1, N, 0);
    press_key();
    run_frame("f7", 0);

    // auto mode with an early fft_m_last, then one more auto frame
    new_frame(90, 90, 90, 100, N, 0);
    auto_mode = 1'b1;
    run_frame("f8", 0);
    chk("f8_frm_set", 32'(err_frame), 32'd1);
    new_frame(80, 90, 85, N - 1, N, 0);
    clr_auto = 1;
    run_frame("f9", 0);
    repeat (5) step();
    chk("f9_stay_hold", 32'(busy), 32'd0);
    chk("f9_stay_ana", 32'(ana_en), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
